garbled_circuit: RTL and testbench

//  Garbler for a fixed 23-input/8-AND/11-output Boolean netlist (free-XOR + half-gates).
//  On start: draws global offset R, hash key and input zero-labels from a seeded PRNG, then garbles the AND gates.

---
 rtl/garbled_circuit.sv | 232 +++++++++++++++++++++++
 tb/tb_garbled_circuit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/garbled_circuit.sv
// Half-gates garbler for a fixed 23-in/8-AND/11-out netlist; no backpressure, KEYS record 3 cycles after start, 22-record stream.
// Optional busy output when GC_BUSY_EN is defined.
module garbled_circuit #(
   parameter int           S    = 5,
   parameter int           K    = 128,
   parameter logic [127:0] SEED = 128'h0123456789ABCDEF0123456789ABCDEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic [2:0]   tag,
   output logic [S-1:0] index0,
   output logic [S-1:0] index1,
   output logic [K-1:0] data0,
   output logic [K-1:0] data1
`ifdef GC_BUSY_EN
   ,
   output logic         busy
`endif
);

   localparam int           NW     = 23;
   localparam logic [K-1:0] SEED_K = K'(SEED);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_KEYS,
      ST_LABELS,
      ST_TABLES,
      ST_MASK
   } state_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [K-1:0] prng_q, prng_d;
   logic [K-1:0] r_q, r_d;
   logic [K-1:0] hk_q, hk_d;
   logic [K-1:0] w_q [NW];
   logic [K-1:0] w_d [NW];
   logic [7:0]   gmask_q, gmask_d;

   logic [2:0]   tag_q, tag_d;
   logic [S-1:0] index0_q, index0_d;
   logic [S-1:0] index1_q, index1_d;
   logic [K-1:0] data0_q, data0_d;
   logic [K-1:0] data1_q, data1_d;
`ifdef GC_BUSY_EN
   logic         busy_q, busy_d;
`endif

   logic [K-1:0] draw_a, draw_b;
   logic [S-1:0] lbl_idx, ga_idx, gb_idx;
   logic [K-1:0] a_l, b_l, ha0, ha1, hb0, hb1, tg, te;
   logic         c0_lsb;

   function automatic logic [K-1:0] xs_step(input logic [K-1:0] x);
      logic [K-1:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 7);
      t = t ^ (t << 17);
      return t;
   endfunction

   function automatic logic [K-1:0] hash(input logic [K-1:0] x, input logic [K-1:0] hk,
                                         input logic [S-1:0] j);
      return {x[K-2:0], x[K-1]} ^ hk ^ K'(j);
   endfunction

   // Datapath for the current label pair / gate, shared by LABELS and TABLES.
   always_comb begin
      draw_a  = xs_step(prng_q);
      draw_b  = xs_step(draw_a);
      lbl_idx = S'({cnt_q, 1'b0});
      ga_idx  = S'({cnt_q[2:0], 1'b0});
      gb_idx  = ga_idx | S'(1);
      a_l     = w_q[ga_idx];
      b_l     = w_q[gb_idx];
      ha0     = hash(a_l, hk_q, ga_idx);
      ha1     = hash(a_l ^ r_q, hk_q, ga_idx);
      hb0     = hash(b_l, hk_q, gb_idx);
      hb1     = hash(b_l ^ r_q, hk_q, gb_idx);
      tg      = ha0 ^ ha1 ^ (b_l[0] ? r_q : '0);
      te      = hb0 ^ hb1 ^ a_l;
      // Only the permute bit of the gate's zero output label is ever needed.
      c0_lsb  = ha0[0] ^ (a_l[0] & tg[0]) ^ hb0[0] ^ (b_l[0] & (te[0] ^ a_l[0]));
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prng_d   = prng_q;
      r_d      = r_q;
      hk_d     = hk_q;
      w_d      = w_q;
      gmask_d  = gmask_q;
      tag_d    = 3'b000;
      index0_d = '0;
      index1_d = '0;
      data0_d  = '0;
      data1_d  = '0;
`ifdef GC_BUSY_EN
      busy_d   = (state_q != ST_IDLE);
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_PREP;
               cnt_d   = '0;
               prng_d  = SEED_K;
            end
         end
         ST_PREP: begin
            prng_d = draw_a;
            if (cnt_q == 4'd0) begin
               r_d    = draw_a | K'(1);
               cnt_d  = 4'd1;
            end else begin
               hk_d    = draw_a;
               cnt_d   = '0;
               state_d = ST_KEYS;
            end
         end
         ST_KEYS: begin
            tag_d   = 3'b001;
            data0_d = r_q;
            data1_d = hk_q;
            cnt_d   = '0;
            state_d = ST_LABELS;
         end
         ST_LABELS: begin
            if (cnt_q < 4'd11) begin
               tag_d                  = 3'b111;
               index0_d               = lbl_idx;
               index1_d               = lbl_idx | S'(1);
               data0_d                = draw_a;
               data1_d                = draw_b;
               w_d[lbl_idx]           = draw_a;
               w_d[lbl_idx | S'(1)]   = draw_b;
               prng_d                 = draw_b;
               cnt_d                  = cnt_q + 4'd1;
            end else begin
               // Odd label count: the last cycle carries lane 0 only.
               tag_d        = 3'b101;
               index0_d     = lbl_idx;
               data0_d      = draw_a;
               w_d[lbl_idx] = draw_a;
               prng_d       = draw_a;
               cnt_d        = '0;
               state_d      = ST_TABLES;
            end
         end
         ST_TABLES: begin
            tag_d                  = 3'b010;
            index0_d               = ga_idx;
            index1_d               = gb_idx;
            data0_d                = tg;
            data1_d                = te;
            gmask_d[cnt_q[2:0]]    = c0_lsb;
            if (cnt_q == 4'd7) begin
               cnt_d   = '0;
               state_d = ST_MASK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_MASK: begin
            tag_d = 3'b011;
            for (int k = 0; k < 8; k++) begin
               data0_d[K-1-k] = gmask_q[k];
            end
            data0_d[K-9]  = w_q[16][0] ^ w_q[17][0];
            data0_d[K-10] = w_q[18][0] ^ w_q[19][0];
            data0_d[K-11] = w_q[20][0] ^ w_q[21][0] ^ w_q[22][0];
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         prng_q   <= '0;
         r_q      <= '0;
         hk_q     <= '0;
         gmask_q  <= '0;
         for (int i = 0; i < NW; i++) begin
            w_q[i] <= '0;
         end
         tag_q    <= '0;
         index0_q <= '0;
         index1_q <= '0;
         data0_q  <= '0;
         data1_q  <= '0;
`ifdef GC_BUSY_EN
         busy_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prng_q   <= prng_d;
         r_q      <= r_d;
         hk_q     <= hk_d;
         gmask_q  <= gmask_d;
         for (int i = 0; i < NW; i++) begin
            w_q[i] <= w_d[i];
         end
         tag_q    <= tag_d;
         index0_q <= index0_d;
         index1_q <= index1_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
`ifdef GC_BUSY_EN
         busy_q   <= busy_d;
`endif
      end
   end

   assign tag    = tag_q;
   assign index0 = index0_q;
   assign index1 = index1_q;
   assign data0  = data0_q;
   assign data1  = data1_q;
`ifdef GC_BUSY_EN
   assign busy   = busy_q;
`endif

endmodule

// File: tb/tb_garbled_circuit.sv
// Scoreboard bench for garbled_circuit: expected records queued at start, monitor pops on every non-idle tag.
module tb_garbled_circuit;
   localparam int           S       = 5;
   localparam int           K       = 128;
   localparam logic [127:0] SEED_TB = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [K-1:0] ONES    = '1;
   localparam logic [K-1:0] LOWM    = ONES >> 11;

   // Input patterns and hand-evaluated plaintext outputs {o10..o0}.
   localparam logic [22:0] PV [6] = '{23'h7FFFFF, 23'h000000, 23'h555555,
                                      23'h2AAAAA, 23'h00000F, 23'h7C000C};
   localparam logic [10:0] PO [6] = '{11'h4FF, 11'h000, 11'h300,
                                      11'h700, 11'h003, 11'h402};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   tag;
   logic [S-1:0] index0, index1;
   logic [K-1:0] data0, data1;
`ifdef GC_BUSY_EN
   logic         busy;
`endif

   garbled_circuit #(.S(S), .K(K), .SEED(SEED_TB)) dut (
      .clk(clk), .rst(rst), .start(start), .tag(tag),
      .index0(index0), .index1(index1), .data0(data0), .data1(data1)
`ifdef GC_BUSY_EN
      , .busy(busy)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   tag;
      logic [S-1:0] i0;
      logic [S-1:0] i1;
      logic [K-1:0] d0;
      logic [K-1:0] d1;
      logic [K-1:0] m0;
      logic [K-1:0] m1;
      int           cyc;
   } rec_t;

   rec_t         exp_q[$];
   rec_t         mon_e;
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           run_e0 = 0;
   bit           run_active = 1'b0;
   logic [K-1:0] m_r, m_hk;
   logic [K-1:0] m_w [23];
   logic [K-1:0] got_r, got_hk, got_mask;
   logic [K-1:0] got_w [23];
   logic [K-1:0] got_tg [8];
   logic [K-1:0] got_te [8];
   logic [K-1:0] prev_tg [8];
   logic [K-1:0] prev_te [8];
   logic [K-1:0] prev_mask;
   bit           have_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic logic [K-1:0] xs(input logic [K-1:0] x);
      logic [K-1:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 7);
      t = t ^ (t << 17);
      return t;
   endfunction

   function automatic logic [K-1:0] hsh(input logic [K-1:0] x, input logic [K-1:0] hk,
                                        input logic [7:0] j);
      return {x[K-2:0], x[K-1]} ^ hk ^ K'(j);
   endfunction

   // Evaluator side: active labels from collected records, decode through the mask.
   function automatic logic [10:0] eval_gc(input logic [22:0] x);
      logic [K-1:0] act [23];
      logic [K-1:0] a, b, wg, we, ol;
      logic [10:0]  res;
      for (int i = 0; i < 23; i++) act[i] = got_w[i] ^ (x[i] ? got_r : '0);
      for (int g = 0; g < 8; g++) begin
         a  = act[2*g];
         b  = act[2*g+1];
         wg = hsh(a, got_hk, 8'(2*g)) ^ (a[0] ? got_tg[g] : '0);
         we = hsh(b, got_hk, 8'(2*g+1)) ^ (b[0] ? (got_te[g] ^ a) : '0);
         ol = wg ^ we;
         res[g] = ol[0] ^ got_mask[K-1-g];
      end
      res[8]  = act[16][0] ^ act[17][0] ^ got_mask[K-9];
      res[9]  = act[18][0] ^ act[19][0] ^ got_mask[K-10];
      res[10] = act[20][0] ^ act[21][0] ^ act[22][0] ^ got_mask[K-11];
      return res;
   endfunction

   function automatic void push(input logic [2:0] t, input int i0, input int i1,
                                input logic [K-1:0] d0, input logic [K-1:0] d1,
                                input logic [K-1:0] m0, input logic [K-1:0] m1, input int c);
      rec_t r;
      r.tag = t; r.i0 = S'(i0); r.i1 = S'(i1);
      r.d0 = d0; r.d1 = d1; r.m0 = m0; r.m1 = m1; r.cyc = c;
      exp_q.push_back(r);
   endfunction

   function automatic void push_stream(input int e0);
      push(3'b001, 0, 0, m_r, m_hk, ONES, ONES, e0 + 3);
      for (int c = 0; c < 11; c++)
         push(3'b111, 2*c, 2*c+1, m_w[2*c], m_w[2*c+1], ONES, ONES, e0 + 4 + c);
      push(3'b101, 22, 0, m_w[22], '0, ONES, ONES, e0 + 15);
      // Table payloads are verified by evaluating the garbled netlist.
      for (int g = 0; g < 8; g++)
         push(3'b010, 2*g, 2*g+1, '0, '0, '0, '0, e0 + 16 + g);
      push(3'b011, 0, 0, '0, '0, LOWM, ONES, e0 + 24);
   endfunction

   task automatic finish_stream();
      int          dup;
      logic [10:0] r;
      dup = 0;
      for (int i = 0; i < 23; i++) begin
         if (got_w[i] == '0) dup++;
         for (int j = i + 1; j < 23; j++) if (got_w[i] == got_w[j]) dup++;
      end
      chk("labels_distinct_nonzero", K'(dup), '0);
      chk("keys_r_lsb", K'(got_r[0]), K'(1'b1));
      for (int v = 0; v < 6; v++) begin
         r = eval_gc(PV[v]);
         chk($sformatf("eval_vec%0d", v), K'(r), K'(PO[v]));
      end
      if (have_prev) begin
         dup = 0;
         for (int g = 0; g < 8; g++) begin
            if (got_tg[g] !== prev_tg[g]) dup++;
            if (got_te[g] !== prev_te[g]) dup++;
         end
         if (got_mask !== prev_mask) dup++;
         chk("rerun_identical", K'(dup), '0);
      end
      prev_tg = got_tg;
      prev_te = got_te;
      prev_mask = got_mask;
      have_prev = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
`ifdef GC_BUSY_EN
         chk("busy", K'(busy), K'(run_active && cyc >= run_e0 + 1 && cyc <= run_e0 + 24));
`endif
         if (tag != 3'b000) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_record: got tag=%b idx0=%0d, required no record", tag, index0);
            end else begin
               mon_e = exp_q.pop_front();
               chk($sformatf("tag@%0d", mon_e.cyc), K'(tag), K'(mon_e.tag));
               chk($sformatf("cycle@%0d", mon_e.cyc), K'(cyc), K'(mon_e.cyc));
               chk($sformatf("idx@%0d", mon_e.cyc), K'({index0, index1}), K'({mon_e.i0, mon_e.i1}));
               chk($sformatf("data0@%0d", mon_e.cyc), data0 & mon_e.m0, mon_e.d0 & mon_e.m0);
               chk($sformatf("data1@%0d", mon_e.cyc), data1 & mon_e.m1, mon_e.d1 & mon_e.m1);
            end
            if (tag[2]) begin
               if (index0 <= 22) got_w[index0] = data0;
               if (tag[1] && index1 <= 22) got_w[index1] = data1;
            end else begin
               case (tag)
                  3'b001: begin got_r = data0; got_hk = data1; end
                  3'b010: if (index0 < 16) begin
                     got_tg[index0 >> 1] = data0;
                     got_te[index0 >> 1] = data1;
                  end
                  3'b011: got_mask = data0;
                  default: ;
               endcase
            end
            if (tag == 3'b011) finish_stream();
         end
      end
   end

   task automatic chk_zero(input string name);
      chk({name, "_ctl"}, K'({tag, index0, index1}), '0);
      chk({name, "_data"}, data0 | data1, '0);
   endtask

   task automatic do_start(output int e0);
      @(posedge clk);
      #1;
      start = 1'b1;
      e0 = cyc + 1;
      run_e0 = e0;
      run_active = 1'b1;
      push_stream(e0);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: %0d records outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) begin
         @(posedge clk);
         #1;
         chk_zero({name, "_idle"});
      end
   endtask

   initial begin
      int           e0;
      logic [K-1:0] x;
      x = SEED_TB[K-1:0];
      x = xs(x); m_r = x | K'(1);
      x = xs(x); m_hk = x;
      for (int i = 0; i < 23; i++) begin
         x = xs(x);
         m_w[i] = x;
      end

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("in_reset");
      rst = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk_zero("idle_no_start");
      end

      do_start(e0);
      wait_done("run1");

      // Start pulse in LABELS must not disturb the stream.
      do_start(e0);
      while (cyc < e0 + 8) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("run2");

      // Abort in TABLES: outputs clear without waiting for a clock edge.
      do_start(e0);
      while (cyc < e0 + 18) begin @(posedge clk); #1; end
      #1;
      chk("abort_pre_tag", K'(tag), K'(3'b010));
      rst = 1'b0;
      run_active = 1'b0;
      #1;
      chk_zero("abort_same_cycle");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk_zero("idle_after_abort");
      end

      do_start(e0);
      wait_done("run3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
